// File: rtl/result_pkt_packer_if.sv
`default_nettype none
// ============================================================================
// Module   : result_pkt_packer_if
// Purpose  : Event input and output-FIFO write bundle for result_pkt_packer.
// Revision : 1.0 - initial release
// ============================================================================
interface result_pkt_packer_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_type;
  logic [15:0] in_pkt_id;
  logic [15:0] in_word_id;
  logic [31:0] in_gen_id;
  logic [15:0] in_hash_num;
  logic [31:0] in_num_processed;
  logic [15:0] dout;
  logic        wr_en;
  logic        full;
  logic        idle;
  logic        err_type;

  modport master (
    output in_valid, in_type, in_pkt_id, in_word_id, in_gen_id,
           in_hash_num, in_num_processed, full,
    input  in_ready, dout, wr_en, idle, err_type
  );

  modport slave (
    input  in_valid, in_type, in_pkt_id, in_word_id, in_gen_id,
           in_hash_num, in_num_processed, full,
    output in_ready, dout, wr_en, idle, err_type
  );
endinterface
`default_nettype wire

// File: rtl/result_pkt_packer.sv
`default_nettype none
// ============================================================================
// Module   : result_pkt_packer
// Purpose  : Packs comparator events into checksummed pkt_comm word streams.
// Revision : 1.0 - initial release
// ============================================================================
module result_pkt_packer #(
  parameter int VERSION          = 2,
  parameter bit DISABLE_CHECKSUM = 1'b0
) (
  input wire                 CLK,
  input wire                 rst_n,
  result_pkt_packer_if.slave bus
);

  localparam logic [1:0] c_type_cmp  = 2'd1;
  localparam logic [1:0] c_type_done = 2'd2;
  localparam logic [7:0] c_version   = 8'(VERSION);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_HCS  = 3'd2,
    S_DATA = 3'd3,
    S_DCS  = 3'd4
  } state_t;

  state_t      r_state;
  logic [1:0]  r_cnt;
  logic [31:0] r_acc;
  logic [15:0] r_lo;
  logic        r_done;
  logic [15:0] r_pkt_id;
  logic [63:0] r_payload;
  logic        r_err;

  logic        w_wr_en;
  logic        w_legal;
  logic        w_last;
  state_t      w_next;
  logic [15:0] w_dout;
  logic [31:0] w_acc;

  assign w_wr_en = (r_state != S_IDLE) && !bus.full;
  assign w_legal = (bus.in_type == c_type_cmp) || (bus.in_type == c_type_done);

  always_comb begin
    w_dout = 16'h0000;
    case (r_state)
      S_HDR: begin
        case (r_cnt)
          2'd0:    w_dout = {(r_done ? 8'hD2 : 8'hD4), c_version};
          2'd1:    w_dout = r_done ? 16'd4 : 16'd8;
          2'd2:    w_dout = 16'h0000;
          default: w_dout = r_pkt_id;
        endcase
      end
      S_HCS, S_DCS: w_dout = r_cnt[0] ? ~r_acc[31:16] : ~r_acc[15:0];
      S_DATA:       w_dout = r_payload[{r_cnt, 4'b0000} +: 16];
      default:      w_dout = 16'h0000;
    endcase
  end

  always_comb begin
    w_last = 1'b0;
    w_next = r_state;
    case (r_state)
      S_HDR: begin
        w_last = (r_cnt == 2'd3);
        w_next = DISABLE_CHECKSUM ? S_DATA : S_HCS;
      end
      S_HCS: begin
        w_last = (r_cnt == 2'd1);
        w_next = S_DATA;
      end
      S_DATA: begin
        w_last = (r_cnt == (r_done ? 2'd1 : 2'd3));
        w_next = DISABLE_CHECKSUM ? S_IDLE : S_DCS;
      end
      S_DCS: begin
        w_last = (r_cnt == 2'd1);
        w_next = S_IDLE;
      end
      default: begin
        w_last = 1'b0;
        w_next = S_IDLE;
      end
    endcase
  end

  // Odd words complete a dword {odd, even}; the data section starts from zero.
  always_comb begin
    w_acc = r_acc;
    if ((r_state == S_HDR || r_state == S_DATA) && r_cnt[0])
      w_acc = r_acc + {w_dout, r_lo};
    if (w_last && w_next == S_DATA)
      w_acc = 32'h0000_0000;
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= 2'd0;
      r_acc     <= 32'h0000_0000;
      r_lo      <= 16'h0000;
      r_done    <= 1'b0;
      r_pkt_id  <= 16'h0000;
      r_payload <= 64'h0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            if (w_legal) begin
              r_state   <= S_HDR;
              r_cnt     <= 2'd0;
              r_acc     <= 32'h0000_0000;
              r_done    <= (bus.in_type == c_type_done);
              r_pkt_id  <= bus.in_pkt_id;
              r_payload <= (bus.in_type == c_type_done)
                         ? {32'h0000_0000, bus.in_num_processed}
                         : {bus.in_hash_num, bus.in_gen_id, bus.in_word_id};
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        default: begin
          if (w_wr_en) begin
            if (!r_cnt[0])
              r_lo <= w_dout;
            r_acc <= w_acc;
            if (w_last) begin
              r_state <= w_next;
              r_cnt   <= 2'd0;
            end else begin
              r_cnt <= r_cnt + 2'd1;
            end
          end
        end
      endcase
    end
  end

  assign bus.dout     = w_dout;
  assign bus.wr_en    = w_wr_en;
  assign bus.in_ready = (r_state == S_IDLE);
  assign bus.idle     = (r_state == S_IDLE);
  assign bus.err_type = r_err;

endmodule
`default_nettype wire
